// File: rtl/systolic_array_pkg.sv
// systolic_array shared definitions:
// default geometry and lane-slice helpers for packed buses.
package systolic_array_pkg;

   localparam int N_DEF      = 4;
   localparam int DATA_W_DEF = 8;
   localparam int ACC_W_DEF  = 32;

   function automatic logic [DATA_W_DEF-1:0] data_lane(
      input logic [N_DEF*DATA_W_DEF-1:0] bus,
      input int                          i
   );
      return bus[i*DATA_W_DEF +: DATA_W_DEF];
   endfunction

   function automatic logic [ACC_W_DEF-1:0] acc_lane(
      input logic [N_DEF*ACC_W_DEF-1:0] bus,
      input int                         i
   );
      return bus[i*ACC_W_DEF +: ACC_W_DEF];
   endfunction

endpackage

// File: rtl/systolic_array_pe.sv
// systolic_pe: one weight-stationary cell.
// Holds act/en/w/psum and performs the signed multiply-add.
module systolic_pe
   import systolic_array_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF,
   parameter int ACC_W  = ACC_W_DEF
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [DATA_W-1:0] i_act,
   input  logic              i_en,
   input  logic [DATA_W-1:0] i_w,
   input  logic              i_wfetch,
   input  logic [ACC_W-1:0]  i_psum,
   output logic [DATA_W-1:0] o_act,
   output logic              o_en,
   output logic [DATA_W-1:0] o_w,
   output logic [ACC_W-1:0]  o_psum
);

   logic [DATA_W-1:0]          r_act;
   logic                       r_en;
   logic [DATA_W-1:0]          r_w;
   logic [ACC_W-1:0]           r_psum;
   logic signed [DATA_W-1:0]   w_a;
   logic signed [DATA_W-1:0]   w_b;
   logic signed [2*DATA_W-1:0] w_prod;
   logic [ACC_W-1:0]           w_term;

   assign w_a    = i_act;
   assign w_b    = r_w;
   assign w_prod = w_a * w_b;

   // Sign-extend the product; a disabled row contributes zero
   always_comb begin
      w_term = '0;
      if (i_en)
         w_term = {{(ACC_W-2*DATA_W){w_prod[2*DATA_W-1]}}, w_prod};
   end

   // Shift activation/valid right, accumulate downward, shift weights on fetch
   always_ff @(posedge clk) begin
      if (rst) begin
         r_act  <= '0;
         r_en   <= 1'b0;
         r_w    <= '0;
         r_psum <= '0;
      end else begin
         r_act  <= i_act;
         r_en   <= i_en;
         r_psum <= i_psum + w_term;
         if (i_wfetch)
            r_w <= i_w;
      end
   end

   assign o_act  = r_act;
   assign o_en   = r_en;
   assign o_w    = r_w;
   assign o_psum = r_psum;

endmodule

// File: rtl/systolic_array.sv
// systolic_array: N x N weight-stationary MAC grid.
// Activations flow right, weights shift down, partial sums flow down.
module systolic_array
   import systolic_array_pkg::*;
#(
   parameter int N      = N_DEF,
   parameter int DATA_W = DATA_W_DEF,
   parameter int ACC_W  = ACC_W_DEF
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [N-1:0]        if_en,
   input  logic [N*DATA_W-1:0] if_data,
   input  logic [N-1:0]        wfetch,
   input  logic [N*DATA_W-1:0] wdata,
   input  logic [N*ACC_W-1:0]  bias,
   output logic [N*ACC_W-1:0]  of_data,
   output logic [N*DATA_W-1:0] if_data_out,
   output logic [N-1:0]        if_en_out,
   output logic [N-1:0]        wfetch_out,
   output logic [N*DATA_W-1:0] wdata_out
);

   logic [DATA_W-1:0] w_act  [N][N+1];
   logic              w_en   [N][N+1];
   logic [DATA_W-1:0] w_wt   [N+1][N];
   logic [ACC_W-1:0]  w_psum [N+1][N];

   assign wfetch_out = wfetch;

   for (genvar r = 0; r < N; r++) begin : g_row
      assign w_act[r][0] = if_data[r*DATA_W +: DATA_W];
      assign w_en[r][0]  = if_en[r];
      assign if_data_out[r*DATA_W +: DATA_W] = w_act[r][N];
      assign if_en_out[r] = w_en[r][N];
   end

   for (genvar c = 0; c < N; c++) begin : g_col
      assign w_wt[0][c]   = wdata[c*DATA_W +: DATA_W];
      assign w_psum[0][c] = bias[c*ACC_W +: ACC_W];
      assign of_data[c*ACC_W +: ACC_W]     = w_psum[N][c];
      assign wdata_out[c*DATA_W +: DATA_W] = w_wt[N][c];
   end

   for (genvar r = 0; r < N; r++) begin : g_pe_r
      for (genvar c = 0; c < N; c++) begin : g_pe_c
         systolic_pe #(
            .DATA_W (DATA_W),
            .ACC_W  (ACC_W)
         ) u_pe (
            .clk      (clk),
            .rst      (rst),
            .i_act    (w_act[r][c]),
            .i_en     (w_en[r][c]),
            .i_w      (w_wt[r][c]),
            .i_wfetch (wfetch[c]),
            .i_psum   (w_psum[r][c]),
            .o_act    (w_act[r][c+1]),
            .o_en     (w_en[r][c+1]),
            .o_w      (w_wt[r+1][c]),
            .o_psum   (w_psum[r+1][c])
         );
      end
   end

endmodule

// File: tb/tb_systolic_array.sv
// tb_systolic_array: directed bench for systolic_array.
// Expected of_data values are queued with a due cycle and checked on arrival.
module tb_systolic_array;
   import systolic_array_pkg::*;

   localparam int N  = N_DEF;
   localparam int DW = DATA_W_DEF;
   localparam int AW = ACC_W_DEF;

   typedef struct {
      int            cyc;
      int            lane;
      logic [AW-1:0] v;
      string         tag;
   } sb_t;

   logic            clk = 1'b0;
   logic            rst;
   logic [N-1:0]    if_en;
   logic [N*DW-1:0] if_data;
   logic [N-1:0]    wfetch;
   logic [N*DW-1:0] wdata;
   logic [N*AW-1:0] bias;
   logic [N*AW-1:0] of_data;
   logic [N*DW-1:0] if_data_out;
   logic [N-1:0]    if_en_out;
   logic [N-1:0]    wfetch_out;
   logic [N*DW-1:0] wdata_out;

   int  checks = 0;
   int  errors = 0;
   int  cyc    = 0;
   sb_t sb[$];

   always #5 clk = ~clk;

   systolic_array dut (
      .clk         (clk),
      .rst         (rst),
      .if_en       (if_en),
      .if_data     (if_data),
      .wfetch      (wfetch),
      .wdata       (wdata),
      .bias        (bias),
      .of_data     (of_data),
      .if_data_out (if_data_out),
      .if_en_out   (if_en_out),
      .wfetch_out  (wfetch_out),
      .wdata_out   (wdata_out)
   );

   task automatic chk(input string tag, input logic [127:0] obs,
                      input logic [127:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic push(input int dly, input int lane,
                       input logic [AW-1:0] v, input string tag);
      sb_t e;
      e.cyc  = cyc + dly;
      e.lane = lane;
      e.v    = v;
      e.tag  = tag;
      sb.push_back(e);
   endtask

   task automatic push_all(input int dly, input logic [AW-1:0] v,
                           input string tag);
      for (int c = 0; c < N; c++) push(dly, c, v, tag);
   endtask

   task automatic tick();
      sb_t e;
      @(posedge clk);
      #1;
      cyc++;
      while (sb.size() > 0 && sb[0].cyc <= cyc) begin
         e = sb.pop_front();
         chk($sformatf("%s_c%0d", e.tag, e.lane),
             128'(acc_lane(of_data, e.lane)), 128'(e.v));
      end
   endtask

   task automatic ticks(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   task automatic load_w(input logic [DW-1:0] v);
      wfetch = '1;
      wdata  = {N{v}};
      ticks(N);
      wfetch = '0;
      wdata  = '0;
   endtask

   initial begin
      rst     = 1'b1;
      if_en   = '1;
      if_data = {N{8'h5A}};
      wfetch  = 4'hA;
      wdata   = {N{8'h33}};
      bias    = {N{32'd77}};
      tick();
      chk("rst_of", 128'(of_data), 128'(0));
      chk("rst_ido", 128'(if_data_out), 128'(0));
      chk("rst_ieo", 128'(if_en_out), 128'(0));
      chk("rst_wdo", 128'(wdata_out), 128'(0));
      chk("rst_wfo", 128'(wfetch_out), 128'(4'hA));
      wfetch = 4'h5;
      #1;
      chk("rst_wfo2", 128'(wfetch_out), 128'(4'h5));

      rst     = 1'b0;
      if_en   = '0;
      if_data = '0;
      wfetch  = '0;
      wdata   = '0;
      bias    = '0;
      tick();

      // weight chain: push 1..4, then 9, 10, 11, 12
      wfetch = '1;
      for (int k = 1; k <= 8; k++) begin
         logic [DW-1:0] v;
         logic [DW-1:0] e;
         v = (k <= 4) ? DW'(k) : DW'(k + 4);
         wdata = {N{v}};
         tick();
         if (k <= 3) e = '0;
         else if (k <= 7) e = DW'(k - 3);
         else e = 8'd9;
         chk($sformatf("wload_p%0d", k), 128'(wdata_out), 128'({N{e}}));
      end
      wfetch = '0;
      wdata  = '0;
      tick();
      chk("whold", 128'(wdata_out), 128'({N{8'd9}}));

      // steady state, all weights 1
      load_w(8'd1);
      if_en   = '1;
      if_data = {N{8'd2}};
      push_all(2*N, 32'd8, "steady");
      ticks(2*N);

      if_en = 4'b0011;
      push_all(2*N, 32'd4, "rowen");
      ticks(2*N);

      if_en = '1;
      bias  = {N{32'd100}};
      push_all(2*N, 32'd108, "bias");
      ticks(2*N);

      // signed product and wrap
      if_en = '0;
      bias  = '0;
      load_w(8'd2);
      if_en   = '1;
      if_data = {N{8'hFD}};
      push_all(2*N, 32'hFFFF_FFE8, "signed");
      ticks(2*N);

      // latency of a single row-0 pulse
      if_en   = '0;
      if_data = '0;
      load_w(8'd3);
      ticks(2*N);
      if_en   = 4'b0001;
      if_data = {24'd0, 8'd5};
      push(5, 2, 32'd0, "lat_t5");
      push(6, 2, 32'd15, "lat_t6");
      push(7, 2, 32'd0, "lat_t7");
      tick();
      if_en   = '0;
      if_data = '0;
      ticks(2);
      chk("lat_ido_t3", 128'(if_data_out[DW-1:0]), 128'(0));
      tick();
      chk("lat_ido_t4", 128'(if_data_out[DW-1:0]), 128'(8'd5));
      chk("lat_ieo_t4", 128'(if_en_out), 128'(4'b0001));
      ticks(3);

      // reset mid-operation drops weights and sums
      if_en   = '1;
      if_data = {N{8'd2}};
      rst     = 1'b1;
      tick();
      chk("mrst_of", 128'(of_data), 128'(0));
      chk("mrst_wdo", 128'(wdata_out), 128'(0));
      rst  = 1'b0;
      bias = {N{32'd7}};
      push_all(2*N, 32'd7, "mrst_bias");
      ticks(2*N);

      for (int i = 0; i < 4 && sb.size() > 0; i++) tick();
      checks++;
      assert (sb.size() == 0) else begin
         errors++;
         $error("FAIL sb_drain observed=%0d expected=0", sb.size());
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
